fifo_ctrl: RTL and testbench

//  Sequential control stage of the 8-entry synchronous FIFO; wraps the combinational

---
 rtl/fifo_ctrl_if.sv | 31 +++
 rtl/fifo_ctrl.sv | 69 ++++++
 tb/tb_fifo_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/fifo_ctrl_if.sv
// Bundle between the FIFO control stage, its requester and the address calculator.
interface fifo_ctrl_if #(
    parameter int unsigned AW = 3,
    parameter int unsigned CW = 4
);
    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] next_head;
    logic [AW-1:0] next_tail;
    logic [CW-1:0] next_data_count;
    logic [2:0]    state;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] data_count;
    logic          full;
    logic          empty;
    logic          wr_ack;
    logic          wr_err;
    logic          rd_ack;
    logic          rd_err;

    modport master (
        output wr_en, rd_en, next_head, next_tail, next_data_count,
        input  state, head, tail, data_count, full, empty, wr_ack, wr_err, rd_ack, rd_err
    );

    modport slave (
        input  wr_en, rd_en, next_head, next_tail, next_data_count,
        output state, head, tail, data_count, full, empty, wr_ack, wr_err, rd_ack, rd_err
    );
endinterface

// File: rtl/fifo_ctrl.sv
// Sequential control stage of the 8-entry FIFO: state/pointer/count registers and
// Moore status decode around the external combinational address calculator.
module fifo_ctrl #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned AW         = 3,
    parameter int unsigned CW         = 4
) (
    input logic         clk,
    input logic         reset_n,
    fifo_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        StInit  = 3'b000,
        StWrite = 3'b001,
        StWrErr = 3'b010,
        StNoOp  = 3'b011,
        StRead  = 3'b100,
        StRdErr = 3'b101
    } state_e;

    localparam logic [CW-1:0] DepthCnt = CW'(FIFO_DEPTH);

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] head_q, tail_q;
    logic [CW-1:0] data_count_q;

    // The request decision looks at next_data_count so a pending op is accounted for.
    always_comb begin
        state_d = StNoOp;
        if (bus.wr_en && !bus.rd_en) begin
            state_d = (bus.next_data_count < DepthCnt) ? StWrite : StWrErr;
        end else if (bus.rd_en && !bus.wr_en) begin
            state_d = (bus.next_data_count != '0) ? StRead : StRdErr;
        end
        // Illegal encodings recover to NO_OP regardless of requests.
        if (state_q == 3'b110 || state_q == 3'b111) begin
            state_d = StNoOp;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StInit;
            head_q       <= '0;
            tail_q       <= '0;
            data_count_q <= '0;
        end else begin
            state_q      <= state_d;
            head_q       <= bus.next_head;
            tail_q       <= bus.next_tail;
            data_count_q <= bus.next_data_count;
        end
    end

    always_comb begin
        bus.state      = state_q;
        bus.head       = head_q;
        bus.tail       = tail_q;
        bus.data_count = data_count_q;
        bus.full       = (data_count_q == DepthCnt);
        bus.empty      = (data_count_q == '0);
        bus.wr_ack     = (state_q == StWrite);
        bus.wr_err     = (state_q == StWrErr);
        bus.rd_ack     = (state_q == StRead);
        bus.rd_err     = (state_q == StRdErr);
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: directed scenarios then random requests against a
// model that tracks only total accepted writes/reads.
module tb_fifo_ctrl;

    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned AW         = 3;
    localparam int unsigned CW         = 4;

    localparam logic [2:0] SInit  = 3'b000;
    localparam logic [2:0] SWrite = 3'b001;
    localparam logic [2:0] SWrErr = 3'b010;
    localparam logic [2:0] SNoOp  = 3'b011;
    localparam logic [2:0] SRead  = 3'b100;
    localparam logic [2:0] SRdErr = 3'b101;

    logic clk;
    logic reset_n;

    fifo_ctrl_if #(.AW(AW), .CW(CW)) bus ();

    fifo_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .AW(AW), .CW(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Stand-in for the address calculator: applies the current state's op.
    assign bus.next_head = (bus.state == SRead) ? bus.head + 3'd1 : bus.head;
    assign bus.next_tail = (bus.state == SWrite) ? bus.tail + 3'd1 : bus.tail;
    assign bus.next_data_count = (bus.state == SWrite) ? bus.data_count + 4'd1 :
                                 (bus.state == SRead)  ? bus.data_count - 4'd1 :
                                 bus.data_count;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: totals of accepted writes/reads, and the totals visible in the registers.
    int         tot_w, tot_r, reg_w, reg_r;
    logic [2:0] exp_state;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        int cnt;
        cnt = reg_w - reg_r;
        chk({where, ".state"}, 32'(bus.state), 32'(exp_state));
        chk({where, ".head"}, 32'(bus.head), 32'(reg_r % FIFO_DEPTH));
        chk({where, ".tail"}, 32'(bus.tail), 32'(reg_w % FIFO_DEPTH));
        chk({where, ".count"}, 32'(bus.data_count), 32'(cnt));
        chk({where, ".full"}, 32'(bus.full), 32'(cnt == FIFO_DEPTH));
        chk({where, ".empty"}, 32'(bus.empty), 32'(cnt == 0));
        chk({where, ".wr_ack"}, 32'(bus.wr_ack), 32'(exp_state == SWrite));
        chk({where, ".wr_err"}, 32'(bus.wr_err), 32'(exp_state == SWrErr));
        chk({where, ".rd_ack"}, 32'(bus.rd_ack), 32'(exp_state == SRead));
        chk({where, ".rd_err"}, 32'(bus.rd_err), 32'(exp_state == SRdErr));
    endtask

    task automatic model_reset();
        tot_w = 0; tot_r = 0; reg_w = 0; reg_r = 0;
        exp_state = SInit;
    endtask

    // One request cycle: drive at negedge, update model at posedge, sample 1 time unit later.
    task automatic step(input logic wr, input logic rd, input string where);
        int occ;
        @(negedge clk);
        bus.wr_en = wr;
        bus.rd_en = rd;
        @(posedge clk);
        reg_w = tot_w;
        reg_r = tot_r;
        occ   = tot_w - tot_r;
        if (wr && !rd) begin
            if (occ < FIFO_DEPTH) begin tot_w++; exp_state = SWrite; end
            else exp_state = SWrErr;
        end else if (rd && !wr) begin
            if (occ > 0) begin tot_r++; exp_state = SRead; end
            else exp_state = SRdErr;
        end else begin
            exp_state = SNoOp;
        end
        #1;
        check_all(where);
    endtask

    // Assert reset between edges and check the outputs clear without a clock.
    task automatic mid_reset(input string where);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all(where);
        @(negedge clk);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        reset_n   = 1'b0;
        model_reset();
        #13;
        check_all("por");
        @(negedge clk);
        reset_n = 1'b1;

        // Fill to full, then one overflowing write.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, "fill");
        step(1'b1, 1'b0, "fill9");
        chk("fill9.wr_err", 32'(bus.wr_err), 32'd1);
        chk("fill9.count", 32'(bus.data_count), 32'd8);
        step(1'b0, 1'b0, "fill_idle");

        // Read from an empty FIFO.
        mid_reset("rst_a");
        step(1'b0, 1'b1, "empty_rd");
        chk("empty_rd.rd_err", 32'(bus.rd_err), 32'd1);

        // Simultaneous requests with three entries stored.
        mid_reset("rst_b");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "sim_wr");
        step(1'b0, 1'b0, "sim_idle");
        step(1'b1, 1'b1, "sim_both");
        chk("sim_both.count", 32'(bus.data_count), 32'd3);

        // Pointer wrap: 8 writes, 8 reads, 3 writes.
        mid_reset("rst_c");
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, "wrap_w");
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, "wrap_r");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "wrap_w2");
        step(1'b0, 1'b0, "wrap_idle");
        chk("wrap.head", 32'(bus.head), 32'd0);
        chk("wrap.tail", 32'(bus.tail), 32'd3);

        // Reset during the fifth write of a burst.
        mid_reset("rst_d");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, "burst");
        @(negedge clk);
        bus.wr_en = 1'b1;
        mid_reset("burst_rst");
        step(1'b1, 1'b0, "post_rst_w");
        step(1'b0, 1'b0, "post_rst_idle");
        chk("post_rst.tail", 32'(bus.tail), 32'd1);

        // Random request mix with occasional resets.
        for (int i = 0; i < 400; i++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            if (r < 2)       mid_reset("rnd_rst");
            else if (r < 45) step(1'b1, 1'b0, "rnd");
            else if (r < 85) step(1'b0, 1'b1, "rnd");
            else if (r < 92) step(1'b1, 1'b1, "rnd");
            else             step(1'b0, 1'b0, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
